// File: rtl/osc_pkg.sv
// osc_pkg: shared FSM/command types and MIDI constants for voice_allocator; CC 64 is decoded only with VOICE_ALLOCATOR_SUSTAIN_EN.
package osc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_SCAN, S_APPLY} state_e;
  typedef enum logic [2:0] {CMD_NONE, CMD_NOTE_ON, CMD_NOTE_OFF, CMD_ALL_OFF, CMD_SUSTAIN} cmd_e;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
  localparam logic [3:0] MIDI_CC = 4'hB;
  localparam logic [6:0] CC_SUSTAIN = 7'd64;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
  function automatic cmd_e decode_cmd(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2,
                                      input logic [3:0] ch);
    if (st[3:0] != ch) return CMD_NONE;
    if (st[7:4] == MIDI_NOTE_ON) return (d2 != 7'd0) ? CMD_NOTE_ON : CMD_NOTE_OFF;
    if (st[7:4] == MIDI_NOTE_OFF) return CMD_NOTE_OFF;
    if (st[7:4] == MIDI_CC && d1 == CC_ALL_NOTES_OFF) return CMD_ALL_OFF;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    if (st[7:4] == MIDI_CC && d1 == CC_SUSTAIN) return CMD_SUSTAIN;
`endif
    return CMD_NONE;
  endfunction
endpackage

// File: rtl/voice_slot.sv
// voice_slot: one voice's note/vel/gate/age state; pending bit exists only with VOICE_ALLOCATOR_SUSTAIN_EN.
module voice_slot #(
  parameter int AGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             assign_i,
  input  logic             release_i,
  input  logic             age_inc_i,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  input  logic             pend_set_i,
  input  logic             flush_i,
`endif
  input  logic [6:0]       note_i,
  input  logic [6:0]       vel_i,
  output logic [6:0]       note_o,
  output logic [6:0]       vel_o,
  output logic             gate_o,
  output logic             trig_o,
  output logic [AGE_W-1:0] age_o
);
  logic [6:0] note_q, note_d, vel_q, vel_d;
  logic gate_q, gate_d, trig_q, trig_d;
  logic [AGE_W-1:0] age_q, age_d;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  logic pend_q, pend_d;
  always_comb begin
    pend_d = ~assign_i & ~release_i & ~flush_i & (pend_q | pend_set_i);
    gate_d = assign_i | (gate_q & ~release_i & ~(flush_i & pend_q));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pend_q <= 1'b0;
    else pend_q <= pend_d;
`else
  assign gate_d = assign_i | (gate_q & ~release_i);
`endif
  always_comb begin
    note_d = assign_i ? note_i : note_q;
    vel_d = assign_i ? vel_i : vel_q;
    trig_d = assign_i;
    age_d = assign_i ? '0 : (age_inc_i && gate_q && age_q != '1) ? age_q + 1'b1 : age_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      note_q <= '0;
      vel_q <= '0;
      gate_q <= 1'b0;
      trig_q <= 1'b0;
      age_q <= '0;
    end else begin
      note_q <= note_d;
      vel_q <= vel_d;
      gate_q <= gate_d;
      trig_q <= trig_d;
      age_q <= age_d;
    end
  assign note_o = note_q;
  assign vel_o = vel_q;
  assign gate_o = gate_q;
  assign trig_o = trig_q;
  assign age_o = age_q;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: MIDI note-on/off to voice-slot allocator (retrigger > free > steal oldest).
// Define VOICE_ALLOCATOR_SUSTAIN_EN to add CC 64 sustain with per-voice pending release.
module voice_allocator import osc_pkg::*; #(
  parameter int         NUM_VOICES = 4,
  parameter logic [3:0] MIDI_CH    = 4'd0,
  parameter int         AGE_W      = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              midi_status,
  input  logic [7:0]              midi_data1,
  input  logic [7:0]              midi_data2,
  input  logic                    midi_msg_rdy,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    busy
);
  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  state_e state_q, state_d;
  cmd_e cmd_q, cmd_d;
  logic [7:0] st_q, st_d;
  logic [6:0] d1_q, d1_d, d2_q, d2_d, cur_note;
  logic [IW-1:0] idx_q, idx_d, match_q, match_d, free_q, free_d, old_q, old_d, tgt;
  logic mf_q, mf_d, ff_q, ff_d, of_q, of_d, on_apply, all_off;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic [AGE_W-1:0] age_w [NUM_VOICES];
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
  logic sus_q, sus_d, flush;
  always_comb begin
    sus_d = sus_q;
    if (state_q == S_APPLY && cmd_q == CMD_SUSTAIN) sus_d = d2_q[6];
    if (state_q == S_APPLY && cmd_q == CMD_ALL_OFF) sus_d = 1'b0;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) sus_q <= 1'b0;
    else sus_q <= sus_d;
  assign flush = state_q == S_APPLY && cmd_q == CMD_SUSTAIN && !d2_q[6];
`endif
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      cmd_q <= CMD_NONE;
      st_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      idx_q <= '0;
      match_q <= '0;
      free_q <= '0;
      old_q <= '0;
      mf_q <= 1'b0;
      ff_q <= 1'b0;
      of_q <= 1'b0;
      old_age_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      st_q <= st_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      idx_q <= idx_d;
      match_q <= match_d;
      free_q <= free_d;
      old_q <= old_d;
      mf_q <= mf_d;
      ff_q <= ff_d;
      of_q <= of_d;
      old_age_q <= old_age_d;
    end
  assign cur_note = voice_note[7*idx_q +: 7];
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    st_d = st_q;
    d1_d = d1_q;
    d2_d = d2_q;
    idx_d = idx_q;
    match_d = match_q;
    free_d = free_q;
    old_d = old_q;
    mf_d = mf_q;
    ff_d = ff_q;
    of_d = of_q;
    old_age_d = old_age_q;
    case (state_q)
      S_IDLE: if (midi_msg_rdy) begin
        st_d = midi_status;
        d1_d = midi_data1[6:0];
        d2_d = midi_data2[6:0];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        cmd_d = decode_cmd(st_q, d1_q, d2_q, MIDI_CH);
        idx_d = '0;
        mf_d = 1'b0;
        ff_d = 1'b0;
        of_d = 1'b0;
        old_age_d = '0;
        state_d = (cmd_d == CMD_NONE) ? S_IDLE :
                  (cmd_d == CMD_NOTE_ON || cmd_d == CMD_NOTE_OFF) ? S_SCAN : S_APPLY;
      end
      S_SCAN: begin
        if (!mf_q && voice_gate[idx_q] && cur_note == d1_q) begin
          mf_d = 1'b1;
          match_d = idx_q;
        end
        if (!ff_q && !voice_gate[idx_q]) begin
          ff_d = 1'b1;
          free_d = idx_q;
        end
        if (voice_gate[idx_q] && (!of_q || age_w[idx_q] > old_age_q)) begin
          of_d = 1'b1;
          old_d = idx_q;
          old_age_d = age_w[idx_q];
        end
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == IW'(NUM_VOICES - 1)) ? S_APPLY : S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign busy = state_q != S_IDLE;
  assign tgt = mf_q ? match_q : ff_q ? free_q : old_q;
  assign on_apply = state_q == S_APPLY && cmd_q == CMD_NOTE_ON;
  assign all_off = state_q == S_APPLY && cmd_q == CMD_ALL_OFF;
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    logic off_hit;
    assign off_hit = state_q == S_APPLY && cmd_q == CMD_NOTE_OFF && mf_q && match_q == IW'(g);
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk(CLK),
      .rst(RST),
      .assign_i(on_apply && tgt == IW'(g)),
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
      .release_i((off_hit && !sus_q) || all_off),
      .pend_set_i(off_hit && sus_q),
      .flush_i(flush),
`else
      .release_i(off_hit || all_off),
`endif
      .age_inc_i(on_apply),
      .note_i(d1_q),
      .vel_i(d2_q),
      .note_o(voice_note[7*g +: 7]),
      .vel_o(voice_vel[7*g +: 7]),
      .gate_o(voice_gate[g]),
      .trig_o(voice_trig[g]),
      .age_o(age_w[g])
    );
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed + random MIDI messages checked against a slot-level reference model.
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int AW = 4;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b0;
  logic [7:0] st = '0, d1 = '0, d2 = '0;
  logic [7*NV-1:0] vn, vv;
  logic [NV-1:0] vg, vt;
  logic busy;
  int checks = 0, errors = 0;
  logic [6:0] m_note [NV];
  logic [6:0] m_vel [NV];
  int m_age [NV];
  bit m_gate [NV];
  bit m_pend [NV];
  bit m_sus;

  voice_allocator #(.NUM_VOICES(NV), .MIDI_CH(4'd0), .AGE_W(AW)) dut (
    .CLK(clk), .RST(rst), .midi_status(st), .midi_data1(d1), .midi_data2(d2), .midi_msg_rdy(rdy),
    .voice_note(vn), .voice_vel(vv), .voice_gate(vg), .voice_trig(vt), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NV-1:0] exp_gate();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = m_gate[i];
    return r;
  endfunction

  task automatic check_state(input string tag);
    logic [7*NV-1:0] en, ev;
    for (int i = 0; i < NV; i++) begin
      en[7*i +: 7] = m_note[i];
      ev[7*i +: 7] = m_vel[i];
    end
    chk({tag, " note"}, 64'(vn), 64'(en));
    chk({tag, " vel"}, 64'(vv), 64'(ev));
    chk({tag, " gate"}, 64'(vg), 64'(exp_gate()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = '0; m_vel[i] = '0; m_age[i] = 0; m_gate[i] = 0; m_pend[i] = 0;
    end
    m_sus = 0;
  endtask

  task automatic model(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [NV-1:0] tr);
    logic [6:0] n, v;
    int t;
    n = a[6:0]; v = b[6:0]; t = -1; tr = '0; lat = 2;
    if (s[3:0] != 4'd0) return;
    if (s[7:4] == 4'h9 && v != 0) begin
      lat = NV + 3;
      for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
      for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
      if (t < 0) begin
        t = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
      end
      for (int i = 0; i < NV; i++) if (i != t && m_gate[i] && m_age[i] < (1 << AW) - 1) m_age[i]++;
      m_note[t] = n; m_vel[t] = v; m_gate[t] = 1; m_age[t] = 0; m_pend[t] = 0; tr[t] = 1'b1;
    end else if (s[7:4] == 4'h8 || s[7:4] == 4'h9) begin
      lat = NV + 3;
      for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
      if (t >= 0) begin
        if (m_sus) m_pend[t] = 1;
        else m_gate[t] = 0;
      end
    end else if (s[7:4] == 4'hB && n == 7'd123) begin
      lat = 3;
      for (int i = 0; i < NV; i++) begin m_gate[i] = 0; m_pend[i] = 0; end
      m_sus = 0;
    end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    else if (s[7:4] == 4'hB && n == 7'd64) begin
      lat = 3;
      if (v >= 64) m_sus = 1;
      else begin
        for (int i = 0; i < NV; i++) if (m_pend[i]) begin m_gate[i] = 0; m_pend[i] = 0; end
        m_sus = 0;
      end
    end
`endif
  endtask

  // Drive one message, optionally inject a second rdy pulse while busy, and check every cycle to lat+1.
  task automatic send(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b, input bit drop = 0);
    int lat;
    logic [NV-1:0] tr, old_g;
    old_g = exp_gate();
    model(s, a, b, lat, tr);
    @(negedge clk); st = s; d1 = a; d2 = b; rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) rdy = 1'b0;
      if (k < lat) begin
        chk("busy during message", 64'(busy), 64'd1);
        chk("no early trig", 64'(vt), 64'd0);
        if (k == lat - 1) chk("gate before latency", 64'(vg), 64'(old_g));
      end else if (k == lat) begin
        chk("busy released", 64'(busy), 64'd0);
        chk("trig pulse", 64'(vt), 64'(tr));
        check_state("result");
      end else chk("trig one cycle", 64'(vt), 64'd0);
      if (drop && k == 2) begin st = 8'h90; d1 = 8'h05; d2 = 8'h7f; rdy = 1'b1; end
    end
  endtask

  initial begin
    logic [NV-1:0] trig_seen;
    logic [7:0] cc_sel [3];
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset gate", 64'(vg), 64'd0);
    chk("reset note", 64'(vn), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    rst = 1'b0;
    send(8'h90, 8'd60, 8'd100);
    send(8'h90, 8'd64, 8'd100);
    send(8'h90, 8'd67, 8'd100);
    send(8'h90, 8'd71, 8'd100);
    send(8'h90, 8'd72, 8'd90);
    chk("steal voice0 note", 64'(vn[6:0]), 64'd72);
    send(8'h90, 8'd64, 8'd80);
    send(8'h80, 8'd64, 8'd0);
    send(8'h91, 8'd60, 8'd100);
    send(8'h90, 8'd72, 8'd0);
    send(8'h90, 8'hBC, 8'hE4);
    send(8'h90, 8'd40, 8'd50, 1'b1);
    send(8'hB0, 8'd123, 8'd0);
    send(8'h90, 8'd50, 8'd10);
    send(8'h90, 8'd52, 8'd20);
    send(8'h90, 8'd55, 8'd30);
    send(8'hB0, 8'd123, 8'd0);
    for (int i = 0; i < NV; i++) send(8'h90, 8'(30 + i), 8'd60);
    for (int i = 0; i < 20; i++) send(8'h90, 8'd32, 8'(1 + i));
    send(8'h90, 8'd90, 8'd99);
    send(8'hB0, 8'd64, 8'd127);
    send(8'h90, 8'd60, 8'd100);
    send(8'h80, 8'd60, 8'd0);
    send(8'hB0, 8'd64, 8'd0);
    cc_sel[0] = 8'd64; cc_sel[1] = 8'd123; cc_sel[2] = 8'd7;
    for (int i = 0; i < 120; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) send(8'h90, 8'(60 + $urandom_range(0, 5)), 8'($urandom_range(0, 127)));
      else if (r < 7) send(8'h80, 8'(60 + $urandom_range(0, 5)), 8'($urandom_range(0, 255)));
      else if (r == 7) send($urandom_range(0, 1) ? 8'h91 : 8'hA0, 8'd60, 8'd100);
      else if (r == 8) send(8'hB0, cc_sel[$urandom_range(0, 2)], 8'($urandom_range(0, 127)));
      else send(8'h90, 8'(8'h80 | (60 + $urandom_range(0, 5))), 8'(8'h80 | $urandom_range(1, 127)));
    end
    @(negedge clk); st = 8'h90; d1 = 8'd33; d2 = 8'd44; rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset gate", 64'(vg), 64'd0);
    chk("async reset note", 64'(vn), 64'd0);
    chk("async reset vel", 64'(vv), 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    trig_seen = '0;
    repeat (NV + 4) begin
      @(negedge clk);
      trig_seen |= vt;
    end
    chk("no trig after abort", 64'(trig_seen), 64'd0);
    check_state("after abort");
    send(8'h90, 8'd61, 8'd101);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice controller between the MIDI decoder and a bank of wave generators.
- Consumes decoded MIDI messages (status, data1, data2, ready pulse) and assigns note-on events to NUM_VOICES voice slots.
- Slot priority: retrigger of the same note, then a free slot, then steal of the oldest slot.
- Drives per-voice note, velocity, gate and a one-cycle trigger pulse for the wave generators and the note display.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..8).
- MIDI_CH, 0, 4-bit MIDI channel accepted; messages on other channels are ignored.
- AGE_W, 4, width of the per-voice saturating age counter.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- midi_status  in  8  decoded status byte
- midi_data1  in  8  data byte 1 (note / CC number)
- midi_data2  in  8  data byte 2 (velocity / CC value)
- midi_msg_rdy  in  1  one-cycle pulse; message bytes are valid in this cycle
- voice_note  out  7*NUM_VOICES  note number per voice; voice i at bits [7i+6:7i]
- voice_vel  out  7*NUM_VOICES  velocity per voice, same packing
- voice_gate  out  NUM_VOICES  1 while the voice's note is held
- voice_trig  out  NUM_VOICES  one-cycle pulse when a voice is (re)started
- busy  out  1  allocator is processing a message

Behaviour:
- Reset (async, RST=1): all outputs 0, all ages 0, FSM in IDLE. Reset mid-scan aborts the message; no partial update.
- FSM states: IDLE -> DECODE -> SCAN -> APPLY -> IDLE.
- IDLE:
  - midi_msg_rdy=1 latches the three bytes and moves to DECODE.
  - busy=1 from the next cycle until APPLY completes.
- DECODE:
  - Low nibble of status != MIDI_CH, or unsupported type: return to IDLE, no change.
  - 0x9n with data2 != 0: NOTE_ON.
  - 0x8n, or 0x9n with data2 = 0: NOTE_OFF.
  - 0xBn with data1 = 123: ALL_OFF; go straight to APPLY.
- SCAN: one voice per cycle, index 0..NUM_VOICES-1 (NUM_VOICES cycles). Records:
  - first voice with gate=1 and note==data1 (match);
  - lowest-index voice with gate=0 (free);
  - gated voice with maximum age, ties to the lowest index (oldest).
- APPLY (one cycle):
  - NOTE_ON target: match if found, else free, else oldest. Target gets note=data1[6:0], vel=data2[6:0], gate=1, trig=1 for exactly one cycle, age=0.
  - NOTE_ON ages: every other gated voice increments age, saturating at 2^AGE_W-1.
  - NOTE_OFF: matching voice gets gate=0 (note and vel held); no match = no change.
  - ALL_OFF: all gates cleared.
- Latency: NOTE_ON/NOTE_OFF outputs are visible NUM_VOICES+3 cycles after the midi_msg_rdy cycle; ALL_OFF is visible after 3 cycles.
- midi_msg_rdy while busy=1: message is dropped, state is unaffected. MIDI byte rate makes this impossible at system clock rates.
- Data bytes with bit 7 set are masked to 7 bits.
- voice_trig is never asserted in the same cycle as a gate clear on that voice.

Optional Feature:
- Macro: VOICE_ALLOCATOR_SUSTAIN_EN.
- Defined:
  - CC 64 (0xBn, data1=64) with data2>=64 sets the sustain flag; data2<64 clears it.
  - While sustained, NOTE_OFF sets a per-voice pending bit instead of clearing gate.
  - On sustain release, APPLY clears gate of all pending voices and clears the pending bits.
  - NOTE_ON to a pending voice clears its pending bit.
  - ALL_OFF clears gates, pending bits and the sustain flag.
- Undefined: CC 64 is ignored; NOTE_OFF clears gate immediately; no pending state exists.

Decomposition:
- Package osc_pkg:
  - FSM state enum;
  - MIDI nibble constants MIDI_NOTE_OFF=4'h8, MIDI_NOTE_ON=4'h9, MIDI_CC=4'hB;
  - CC constants CC_SUSTAIN=64, CC_ALL_NOTES_OFF=123;
  - decoded-command enum (NONE, NOTE_ON, NOTE_OFF, ALL_OFF, SUSTAIN).
- One sub-module, voice_slot, instantiated NUM_VOICES times:
  - holds note/vel/gate/age (and pending when the sustain feature is built);
  - applies assign / release / age-increment strobes from the FSM.

Test Plan:
1. Reset, then 0x90 60 100 -> after 7 cycles voice0 note=60 vel=100 gate=1, voice_trig=0001 for one cycle; busy high for 6 cycles.
2. Note-ons 60, 64, 67, 71, then 0x90 72 90 -> all four slots full; voice0 (oldest) stolen: note=72, gate stays 1, trig pulse on voice0.
3. 0x90 64 80 with 64 held on voice1 -> retrigger voice1 (vel=80, trig), no new slot used; then 0x80 64 0 -> voice1 gate=0, others unchanged.
4. 0x91 60 100 with MIDI_CH=0 -> no output change, busy returns 0 after DECODE; 0x90 60 0 -> treated as note-off.
5. Three notes held, then 0xB0 123 0 -> all gates 0 three cycles later; assert RST during SCAN of a note-on -> all outputs 0, no trig.
6. With VOICE_ALLOCATOR_SUSTAIN_EN defined: 0xB0 64 127, note-on 60, note-off 60 -> gate stays 1; 0xB0 64 0 -> gate=0. Without the macro the same sequence gives gate=0 at the note-off.
